// File: rtl/ram_be_sdp_clr_if.sv
// Bus bundle for ram_be_sdp_clr: port A write, port B read, enable and status.
interface ram_be_sdp_clr_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              ClockEn;
    logic              Busy;
    logic              WE;
    logic [BE_W-1:0]   ByteEn;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Data;
    logic              RdEn;
    logic [ADDR_W-1:0] RdAddress;
    logic [DATA_W-1:0] Q;
    logic              QValid;
    logic              Collision;

    // Requester side: drives enables, writes and read requests.
    modport master (
        output ClockEn, WE, ByteEn, Address, Data, RdEn, RdAddress,
        input  Busy, Q, QValid, Collision
    );

    // RAM side.
    modport slave (
        input  ClockEn, WE, ByteEn, Address, Data, RdEn, RdAddress,
        output Busy, Q, QValid, Collision
    );
endinterface

// File: rtl/ram_be_sdp_clr.sv
// Simple-dual-port byte-enabled RAM with post-reset clear engine,
// 1- or 2-cycle registered read latency and selectable collision mode.
module ram_be_sdp_clr #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input logic            Clock,
    input logic            Reset,
    ram_be_sdp_clr_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Control and pipeline registers
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_coll_q, s1_coll_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              qvalid_q, qvalid_d;
    logic              coll_q, coll_d;

    // Storage array; contents deliberately survive reset
    logic [DATA_W-1:0] mem [DEPTH];

    // Port decode and memory write mux
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              hit_c;
    logic [DATA_W-1:0] old_word_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [BE_W-1:0]   mem_be_c;

    // Accept reads/writes only when enabled, out of reset and past the clear.
    always_comb begin
        wr_acc_c   = bus.ClockEn && !Reset && (state_q == ST_READY) && bus.WE;
        rd_acc_c   = bus.ClockEn && !Reset && (state_q == ST_READY) && bus.RdEn;
        hit_c      = wr_acc_c && rd_acc_c && (bus.Address == bus.RdAddress);
        old_word_c = mem[bus.RdAddress];
        rd_word_c  = old_word_c;
        // Write-first merge: new bytes in enabled lanes, old bytes elsewhere
        if ((WRITE_FIRST != 0) && hit_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (bus.ByteEn[i]) begin
                    rd_word_c[8*i +: 8] = bus.Data[8*i +: 8];
                end
            end
        end
    end

    // Select the single memory write source: clear engine or port A.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.Address;
        mem_wdata_c = bus.Data;
        mem_be_c    = bus.ByteEn;
        if (bus.ClockEn && !Reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we_c    = 1'b1;
                mem_addr_c  = clr_addr_q;
                mem_wdata_c = '0;
                mem_be_c    = '1;
            end else if (bus.WE) begin
                mem_we_c = 1'b1;
            end
        end
    end

    // Byte-lane memory write.
    always_ff @(posedge Clock) begin
        if (mem_we_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_addr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Next state for clear engine and read pipeline; everything holds when disabled.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        s1_data_d  = s1_data_q;
        s1_vld_d   = s1_vld_q;
        s1_coll_d  = s1_coll_q;
        q_d        = q_q;
        qvalid_d   = qvalid_q;
        coll_d     = coll_q;
        if (bus.ClockEn) begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d    = ST_READY;
                        busy_d     = 1'b0;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase

            // Stage 1 only matters for the 2-cycle latency configuration
            s1_vld_d  = rd_acc_c;
            s1_coll_d = hit_c;
            if (rd_acc_c) begin
                s1_data_d = rd_word_c;
            end

            if (RD_LATENCY == 1) begin
                qvalid_d = rd_acc_c;
                coll_d   = hit_c;
                if (rd_acc_c) begin
                    q_d = rd_word_c;
                end
            end else begin
                qvalid_d = s1_vld_q;
                coll_d   = s1_coll_q;
                if (s1_vld_q) begin
                    q_d = s1_data_q;
                end
            end
        end
    end

    // State registers; synchronous reset overrides the enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
            busy_q     <= (CLEAR_ON_RESET != 0);
            s1_data_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_coll_q  <= 1'b0;
            q_q        <= '0;
            qvalid_q   <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            s1_data_q  <= s1_data_d;
            s1_vld_q   <= s1_vld_d;
            s1_coll_q  <= s1_coll_d;
            q_q        <= q_d;
            qvalid_q   <= qvalid_d;
            coll_q     <= coll_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Q         = q_q;
    assign bus.QValid    = qvalid_q;
    assign bus.Collision = coll_q;
endmodule

// File: tb/tb_ram_be_sdp_clr.sv
// Scoreboard bench for ram_be_sdp_clr: three configurations share one stimulus stream.
//   dut 0: latency 1, read-first,  clear on reset
//   dut 1: latency 2, write-first, clear on reset
//   dut 2: latency 1, read-first,  no clear
module tb_ram_be_sdp_clr;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_drv = 1'b1;
    logic        ce_drv  = 1'b1;
    logic        we_drv  = 1'b0;
    logic        rde_drv = 1'b0;
    logic [1:0]  be_drv  = 2'b00;
    logic [3:0]  wa_drv  = 4'h0;
    logic [3:0]  ra_drv  = 4'h0;
    logic [15:0] wd_drv  = 16'h0000;

    ram_be_sdp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    ram_be_sdp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();
    ram_be_sdp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) if_c ();

    assign if_a.ClockEn = ce_drv;  assign if_b.ClockEn = ce_drv;  assign if_c.ClockEn = ce_drv;
    assign if_a.WE = we_drv;       assign if_b.WE = we_drv;       assign if_c.WE = we_drv;
    assign if_a.ByteEn = be_drv;   assign if_b.ByteEn = be_drv;   assign if_c.ByteEn = be_drv;
    assign if_a.Address = wa_drv;  assign if_b.Address = wa_drv;  assign if_c.Address = wa_drv;
    assign if_a.Data = wd_drv;     assign if_b.Data = wd_drv;     assign if_c.Data = wd_drv;
    assign if_a.RdEn = rde_drv;    assign if_b.RdEn = rde_drv;    assign if_c.RdEn = rde_drv;
    assign if_a.RdAddress = ra_drv; assign if_b.RdAddress = ra_drv; assign if_c.RdAddress = ra_drv;

    ram_be_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
        dut_a (.Clock(clk), .Reset(rst_drv), .bus(if_a));
    ram_be_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
        dut_b (.Clock(clk), .Reset(rst_drv), .bus(if_b));
    ram_be_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(0))
        dut_c (.Clock(clk), .Reset(rst_drv), .bus(if_c));

    logic [15:0] q_s [3];
    logic        v_s [3];
    logic        c_s [3];
    logic        b_s [3];
    assign q_s[0] = if_a.Q;  assign v_s[0] = if_a.QValid;  assign c_s[0] = if_a.Collision;  assign b_s[0] = if_a.Busy;
    assign q_s[1] = if_b.Q;  assign v_s[1] = if_b.QValid;  assign c_s[1] = if_b.Collision;  assign b_s[1] = if_b.Busy;
    assign q_s[2] = if_c.Q;  assign v_s[2] = if_c.QValid;  assign c_s[2] = if_c.Collision;  assign b_s[2] = if_c.Busy;

    typedef struct {
        logic [15:0] data;
        logic        coll;
        int unsigned due;
    } rd_exp_t;

    rd_exp_t sb [3][$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s dut=%0d got=%h expected=%h", nm, id, got, exp_v);
        end
    endtask

    function automatic int unsigned lat(input int id);
        return (id == 1) ? 32'd2 : 32'd1;
    endfunction

    // Enabled-edge counter and edge qualifiers for the monitor
    int unsigned en_cnt   = 0;
    logic        en_edge  = 1'b0;
    logic        rst_edge = 1'b0;
    logic        mon_on   = 1'b0;

    always @(posedge clk) begin
        en_edge  <= ce_drv;
        rst_edge <= rst_drv;
        if (ce_drv) en_cnt <= en_cnt + 1;
        if (rst_drv) mon_on <= 1'b1;
    end

    // Monitor: pops on each enabled QValid, checks hold on disabled edges.
    logic [15:0] pq [3];
    logic        pv [3];
    logic        pc [3];
    rd_exp_t     mon_e;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                if (!rst_edge) begin
                    if (en_edge) begin
                        if (v_s[i] === 1'b1) begin
                            if (sb[i].size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_qvalid dut=%0d got Q=%h expected no read", i, q_s[i]);
                            end else begin
                                mon_e = sb[i].pop_front();
                                chk("rd_data", i, 32'(q_s[i]), 32'(mon_e.data));
                                chk("rd_coll", i, 32'(c_s[i]), 32'(mon_e.coll));
                                chk("rd_latency", i, 32'(en_cnt), 32'(mon_e.due));
                            end
                        end
                    end else begin
                        chk("hold_q", i, 32'(q_s[i]), 32'(pq[i]));
                        chk("hold_qvalid", i, 32'(v_s[i]), 32'(pv[i]));
                        chk("hold_coll", i, 32'(c_s[i]), 32'(pc[i]));
                    end
                end
                pq[i] = q_s[i];
                pv[i] = v_s[i];
                pc[i] = c_s[i];
            end
        end
    end

    task automatic tick(input logic c);
        ce_drv = c;
        @(posedge clk);
        #1;
        we_drv  = 1'b0;
        rde_drv = 1'b0;
        be_drv  = 2'b00;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        we_drv = 1'b1;
        wa_drv = a;
        wd_drv = d;
        be_drv = b;
    endtask

    task automatic rd(input logic [3:0] a);
        rde_drv = 1'b1;
        ra_drv  = a;
    endtask

    // Must be called just before an enabled tick that accepts the read.
    task automatic expect_rd(input int id, input logic [15:0] d, input logic c);
        rd_exp_t e;
        e.data = d;
        e.coll = c;
        e.due  = en_cnt + lat(id);
        sb[id].push_back(e);
    endtask

    task automatic expect_all(input logic [15:0] d, input logic c);
        for (int i = 0; i < 3; i++) expect_rd(i, d, c);
    endtask

    task automatic chk_busy(input logic ba, input logic bb, input logic bc);
        chk("busy", 0, 32'(b_s[0]), 32'(ba));
        chk("busy", 1, 32'(b_s[1]), 32'(bb));
        chk("busy", 2, 32'(b_s[2]), 32'(bc));
    endtask

    function automatic logic [15:0] pat(input logic [3:0] a);
        return {4'hB, a, 4'h4, ~a};
    endfunction

    initial begin
        // Power-up reset and reset-state checks
        rst_drv = 1'b1;
        repeat (2) tick(1'b1);
        chk_busy(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_q", i, 32'(q_s[i]), 32'h0);
            chk("rst_qvalid", i, 32'(v_s[i]), 32'h0);
            chk("rst_coll", i, 32'(c_s[i]), 32'h0);
        end
        rst_drv = 1'b0;
        repeat (15) tick(1'b1);
        chk_busy(1'b1, 1'b1, 1'b0);
        tick(1'b1);
        chk_busy(1'b0, 1'b0, 1'b0);

        // Preload 0xFFFF everywhere
        for (int a = 0; a < 16; a++) begin
            wr(4'(a), 16'hFFFF, 2'b11);
            tick(1'b1);
        end

        // Reset, then abort the clear at cycle 9 with a second reset
        rst_drv = 1'b1;
        tick(1'b1);
        rst_drv = 1'b0;
        chk_busy(1'b1, 1'b1, 1'b0);
        rd(4'd3);
        expect_rd(2, 16'hFFFF, 1'b0);
        tick(1'b1);
        repeat (3) tick(1'b1);
        tick(1'b0);
        repeat (4) tick(1'b1);
        chk_busy(1'b1, 1'b1, 1'b0);
        rst_drv = 1'b1;
        tick(1'b1);
        rst_drv = 1'b0;
        chk_busy(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) wr(4'd0, 16'h5A5A, 2'b11);
            tick(1'b1);
            if (k == 15) chk_busy(1'b1, 1'b1, 1'b0);
            if (k == 16) chk_busy(1'b0, 1'b0, 1'b0);
            if (k % 4 == 0) tick(1'b0);
        end

        // Read back the whole array
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            expect_rd(0, 16'h0000, 1'b0);
            expect_rd(1, 16'h0000, 1'b0);
            expect_rd(2, (a == 0) ? 16'h5A5A : 16'hFFFF, 1'b0);
            tick(1'b1);
        end

        // Byte-lane merge then immediate read
        wr(4'd5, 16'hA5C3, 2'b11);
        tick(1'b1);
        wr(4'd5, 16'h1200, 2'b10);
        tick(1'b1);
        rd(4'd5);
        expect_all(16'h12C3, 1'b0);
        tick(1'b1);
        repeat (2) tick(1'b1);

        // Collisions
        wr(4'd7, 16'h1111, 2'b11);
        tick(1'b1);
        wr(4'd7, 16'hABCD, 2'b01);
        rd(4'd7);
        expect_rd(0, 16'h1111, 1'b1);
        expect_rd(1, 16'h11CD, 1'b1);
        expect_rd(2, 16'h1111, 1'b1);
        tick(1'b1);
        rd(4'd7);
        expect_all(16'h11CD, 1'b0);
        tick(1'b1);
        wr(4'd7, 16'hFFFF, 2'b00);
        rd(4'd7);
        expect_all(16'h11CD, 1'b1);
        tick(1'b1);
        wr(4'd8, 16'h2222, 2'b11);
        rd(4'd7);
        expect_all(16'h11CD, 1'b0);
        tick(1'b1);
        rd(4'd8);
        expect_all(16'h2222, 1'b0);
        tick(1'b1);
        repeat (2) tick(1'b1);

        // Fill with a pattern, then a ByteEn=0 write that must not land
        for (int a = 0; a < 16; a++) begin
            wr(4'(a), pat(4'(a)), 2'b11);
            tick(1'b1);
        end
        wr(4'd2, 16'hDEAD, 2'b00);
        tick(1'b1);

        // Streaming reads with ClockEn toggling
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            expect_all(pat(4'(a)), 1'b0);
            tick(1'b1);
            rd(4'(a));
            tick(1'b0);
        end
        repeat (4) tick(1'b1);

        for (int i = 0; i < 3; i++) chk("pending_reads", i, 32'(sb[i].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_be_sdp_clr.md
# ram_be_sdp_clr

Parametrised simple-dual-port byte-enabled RAM, the successor to the 16-bit single-port byte-lane RAM used in the PCIe DMA test designs. Port A writes with per-byte enables; port B reads with a configurable 1- or 2-cycle registered latency and a valid flag. A built-in clear engine zero-fills the whole array after reset, and collision handling between port A and port B is selectable. The block sits between the DMA engine's write path and the host-readback path as a descriptor/data scratch buffer.

## Interface

- DATA_W, 32, data width in bits; must be a multiple of 8 (byte lanes = DATA_W/8)
- ADDR_W, 10, address width; depth = 2^ADDR_W words
- RD_LATENCY, 1, read latency in enabled cycles; legal values are 1 and 2
- WRITE_FIRST, 0, collision mode: 0 returns old data, 1 returns byte-merged new data
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset; 0 skips the clear

- Clock  in  1  single clock; all logic is on the rising edge
- Reset  in  1  synchronous, active-high
- ClockEn  in  1  global enable; when low, no state changes (memory, pipeline, clear engine all hold)
- Busy  out  1  high while the clear engine runs
- WE  in  1  port A write strobe
- ByteEn  in  DATA_W/8  port A byte-lane enables; bit i gates Data[8i+7:8i]
- Address  in  ADDR_W  port A address
- Data  in  DATA_W  port A write data
- RdEn  in  1  port B read request
- RdAddress  in  ADDR_W  port B address
- Q  out  DATA_W  port B read data, registered
- QValid  out  1  Q holds the data for a request accepted RD_LATENCY enabled cycles earlier
- Collision  out  1  the read returned on Q coincided with a port A write to the same address

## Operation

- Two states: CLEAR and READY. Reset (takes priority over ClockEn) sets the state to CLEAR when CLEAR_ON_RESET=1 and to READY otherwise. It also clears the clear counter, Busy (= CLEAR_ON_RESET), Q=0, QValid=0, Collision=0 and all pipeline stages. Memory contents are not reset.
- No memory write of any kind occurs in a cycle with Reset high.
- CLEAR: on each cycle with ClockEn=1, write all-zero to word clr_addr (all lanes), then increment. When clr_addr = 2^ADDR_W-1 is written, go to READY and drop Busy in the same edge.
- While in CLEAR, WE and RdEn are ignored and QValid stays 0.
- Reset asserted mid-clear restarts the clear from address 0.
- READY, write: WE=1 with ClockEn=1 writes only the lanes whose ByteEn bit is set. WE with ByteEn=0 is a no-op.
- READY, read: RdEn=1 with ClockEn=1 accepts a read of RdAddress.
- Collision (WE and RdEn accepted together, Address = RdAddress):
  - WRITE_FIRST=0 returns the pre-write word.
  - WRITE_FIRST=1 returns the new bytes in enabled lanes and the old bytes elsewhere.
  - Collision is flagged in both modes, and it is also flagged when ByteEn=0.
- Q holds its last value when QValid is 0. Q is never cleared except by Reset.

## Timing

- Read accepted at enabled edge n.
- RD_LATENCY=1: Q, QValid=1 and Collision appear after edge n. With RD_LATENCY=2 they appear after the next enabled edge.
- QValid and Collision are single-cycle pulses per accepted read, unless ClockEn is low, in which case they hold.
- ClockEn low freezes the pipeline. Output timing counts enabled edges only.
- Back-to-back reads every cycle give full throughput: one result per enabled cycle.
- Write-then-read of the same address on the next cycle returns the new data (no hazard).
- Clear duration: exactly 2^ADDR_W enabled cycles after the last Reset-high cycle. The first READY-accepted operation can occur on the enabled edge after Busy falls.

## Test plan

Bench configuration: DATA_W=16, ADDR_W=4, unless noted otherwise.

- Reset with CLEAR_ON_RESET=1 after preloading 0xFFFF everywhere -> Busy high for 16 enabled cycles, then 0; reads of all 16 addresses return 0x0000; WE during Busy has no effect.
- Write 0xA5C3 to address 5 with ByteEn=11, then 0x1200 with ByteEn=10; read address 5 -> Q=0x12C3, QValid one cycle after accept (RD_LATENCY=1), two cycles after (RD_LATENCY=2).
- Address 7 holds 0x1111; same-cycle write 0xABCD with ByteEn=01 and read of address 7 -> Q=0x1111 when WRITE_FIRST=0, Q=0x11CD when WRITE_FIRST=1; Collision=1 with QValid in both.
- Streaming reads of addresses 0..15 with ClockEn toggling 1,0,1,0 -> outputs hold while ClockEn=0, data in order, no drops or duplicates, 16 QValid pulses.
- Reset pulsed at clear cycle 9 -> Busy stays high, clear restarts at address 0, and Busy falls 16 enabled cycles after Reset drops.
- CLEAR_ON_RESET=0: Reset -> Busy=0 immediately, memory keeps its prior contents, and a read the cycle after Reset returns the stored value.
